// File: rtl/cmp_rs_pkg.sv
// Shared types for the compare reservation station: the slt/sltu funct3 encodings,
// the ROB tag and CDB data widths, and the station entry layout.
package cmp_rs_pkg;

  localparam int ROB_TAG_WIDTH = 3;
  localparam int XLEN_W        = 32;

  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;

  typedef logic [ROB_TAG_WIDTH-1:0] rob_tag_t;
  typedef logic [XLEN_W-1:0]        cdb_data_t;

  typedef struct packed {
    logic      rdy;
    cdb_data_t data;
    rob_tag_t  tag;
  } rs_operand_t;

  typedef struct packed {
    logic        valid;
    logic [2:0]  funct3;
    rob_tag_t    rob_tag;
    rs_operand_t src1;
    rs_operand_t src2;
  } cmp_rs_entry_t;

  function automatic logic is_cmp_funct3(input logic [2:0] f);
    return (f == FUNCT3_SLT) || (f == FUNCT3_SLTU);
  endfunction

endpackage

// File: rtl/age_picker.sv
// Age matrix for the station entries plus a one-hot oldest-ready picker.
// age_reg[i][j] = 1 means entry i was dispatched before entry j.
module age_picker #(
  parameter int NUM_ENTRIES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_en,
  input  logic [NUM_ENTRIES-1:0] alloc_onehot,
  input  logic [NUM_ENTRIES-1:0] ready,
  output logic [NUM_ENTRIES-1:0] pick_onehot
);

  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age_reg;

  // A new entry is younger than everyone: clear its row, set its column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_reg <= '0;
    end else if (alloc_en) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        for (int j = 0; j < NUM_ENTRIES; j++) begin
          if (alloc_onehot[i]) begin
            age_reg[i][j] <= 1'b0;
          end else if (alloc_onehot[j]) begin
            age_reg[i][j] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    logic blocked;
    pick_onehot = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (ready[j] && age_reg[j][i]) blocked = 1'b1;
      end
      pick_onehot[i] = ready[i] && !blocked;
    end
  end

endmodule

// File: rtl/cmp_rs.sv
// Reservation station for the shared slt/sltu compare unit: dispatch, CDB wakeup,
// oldest-ready issue and a result register held until the CDB arbiter grants it.
module cmp_rs
  import cmp_rs_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_WIDTH   = ROB_TAG_WIDTH,
  parameter int XLEN        = XLEN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 dispatch_valid,
  output logic                 dispatch_ready,
  input  logic [2:0]           dispatch_funct3,
  input  logic [TAG_WIDTH-1:0] dispatch_rob_tag,
  input  logic                 dispatch_src1_valid,
  input  logic [XLEN-1:0]      dispatch_src1_data,
  input  logic [TAG_WIDTH-1:0] dispatch_src1_tag,
  input  logic                 dispatch_src2_valid,
  input  logic [XLEN-1:0]      dispatch_src2_data,
  input  logic [TAG_WIDTH-1:0] dispatch_src2_tag,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  input  logic [XLEN-1:0]      cdb_data,
  output logic [2:0]           cmp_funct3,
  output logic [XLEN-1:0]      cmp_first,
  output logic [XLEN-1:0]      cmp_second,
  input  logic [XLEN-1:0]      cmp_result,
  output logic                 res_valid,
  output logic [TAG_WIDTH-1:0] res_tag,
  output logic [XLEN-1:0]      res_data,
  input  logic                 res_grant
);

  cmp_rs_entry_t entries_reg [NUM_ENTRIES];
  cmp_rs_entry_t new_entry;

  logic [NUM_ENTRIES-1:0] valid_vec;
  logic [NUM_ENTRIES-1:0] ready_vec;
  logic [NUM_ENTRIES-1:0] alloc_onehot;
  logic [NUM_ENTRIES-1:0] pick_onehot;
  logic                   dispatch_fire;
  logic                   issue_en;
  logic [TAG_WIDTH-1:0]   pick_rob_tag;

  function automatic rs_operand_t make_operand(
    input logic                 src_valid,
    input logic [XLEN-1:0]      src_data,
    input logic [TAG_WIDTH-1:0] src_tag,
    input logic                 bus_valid,
    input logic [TAG_WIDTH-1:0] bus_tag,
    input logic [XLEN-1:0]      bus_data
  );
    rs_operand_t op;
    op.tag = src_tag;
    if (src_valid) begin
      op.rdy  = 1'b1;
      op.data = src_data;
    end else if (bus_valid && bus_tag == src_tag) begin
      op.rdy  = 1'b1;
      op.data = bus_data;
    end else begin
      op.rdy  = 1'b0;
      op.data = '0;
    end
    return op;
  endfunction

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_status
    assign valid_vec[gi] = entries_reg[gi].valid;
    assign ready_vec[gi] = entries_reg[gi].valid && entries_reg[gi].src1.rdy &&
                           entries_reg[gi].src2.rdy;
  end

  // Lowest-index free slot wins the allocation.
  always_comb begin
    alloc_onehot = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        alloc_onehot    = '0;
        alloc_onehot[i] = 1'b1;
      end
    end
  end

  assign dispatch_ready = ~&valid_vec;
  assign dispatch_fire  = dispatch_valid && dispatch_ready && !flush;
  assign issue_en       = (|ready_vec) && (!res_valid || res_grant) && !flush;

  always_comb begin
    new_entry         = '0;
    new_entry.valid   = 1'b1;
    new_entry.funct3  = dispatch_funct3;
    new_entry.rob_tag = dispatch_rob_tag;
    new_entry.src1    = make_operand(dispatch_src1_valid, dispatch_src1_data, dispatch_src1_tag,
                                     cdb_valid, cdb_tag, cdb_data);
    new_entry.src2    = make_operand(dispatch_src2_valid, dispatch_src2_data, dispatch_src2_tag,
                                     cdb_valid, cdb_tag, cdb_data);
  end

  age_picker #(.NUM_ENTRIES(NUM_ENTRIES)) u_age_picker (
    .clk          (clk),
    .rst          (rst),
    .alloc_en     (dispatch_fire),
    .alloc_onehot (alloc_onehot),
    .ready        (ready_vec),
    .pick_onehot  (pick_onehot)
  );

  // The pick is one-hot, so an OR-reduction acts as the mux and yields 0 when idle.
  always_comb begin
    cmp_funct3   = '0;
    cmp_first    = '0;
    cmp_second   = '0;
    pick_rob_tag = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (pick_onehot[i]) begin
        cmp_funct3   = cmp_funct3   | entries_reg[i].funct3;
        cmp_first    = cmp_first    | entries_reg[i].src1.data;
        cmp_second   = cmp_second   | entries_reg[i].src2.data;
        pick_rob_tag = pick_rob_tag | entries_reg[i].rob_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries_reg[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries_reg[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (issue_en && pick_onehot[i]) begin
          entries_reg[i].valid <= 1'b0;
        end else if (dispatch_fire && alloc_onehot[i]) begin
          entries_reg[i] <= new_entry;
        end else if (entries_reg[i].valid && cdb_valid) begin
          if (!entries_reg[i].src1.rdy && entries_reg[i].src1.tag == cdb_tag) begin
            entries_reg[i].src1.rdy  <= 1'b1;
            entries_reg[i].src1.data <= cdb_data;
          end
          if (!entries_reg[i].src2.rdy && entries_reg[i].src2.tag == cdb_tag) begin
            entries_reg[i].src2.rdy  <= 1'b1;
            entries_reg[i].src2.data <= cdb_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_data  <= '0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (issue_en) begin
      res_valid <= 1'b1;
      res_tag   <= pick_rob_tag;
      res_data  <= cmp_result;
    end else if (res_grant) begin
      res_valid <= 1'b0;
    end
  end

endmodule
